// File: rtl/mixer.sv
// -----------------------------------------------------------------------------
// mixer
//   Combines the per-voice oscillator samples into one mono sample. The sum is
//   divided by the number of active voices (through a reciprocal table, so no
//   divider is built), scaled by the master volume and saturated to the sample
//   width.
//
//   Ports
//     clk            system clock, all state updates on posedge
//     rstn           asynchronous active-low reset; clears the pipeline and out
//     waves          N_WAVEGENS signed voice samples, WIDTH+FIXED_POINT bits each
//     master_volume  unsigned gain, FIXED_POINT fractional bits (1.0 = 1<<FP)
//     num_enabled    signed count of active voices (clamped to 1..N_WAVEGENS)
//     out            mixed, normalised, scaled and saturated sample
//
//   Flow control: there is no handshake. A new set of waves/num_enabled is
//   accepted on every posedge, and out is valid every cycle. The result for
//   the inputs captured at edge k appears on out after edge k+2 (three clocks
//   of latency counting the capture edge). master_volume is sampled one edge
//   after the waves that it scales.
//
//   Pipeline
//     S1  sum_q  = sign-extended sum of all voices, n_q = clamped voice count
//     S2  norm_q = (sum_q * ceil(2^24 / n_q)) >>> 24, vol_q = master_volume
//     S3  out_q  = saturate((norm_q * vol_q) >>> FIXED_POINT)
// -----------------------------------------------------------------------------
module mixer #(
  parameter int WIDTH       = 24,
  parameter int FIXED_POINT = 8,
  parameter int N_WAVEGENS  = 8
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic signed [WIDTH+FIXED_POINT-1:0] waves [N_WAVEGENS],
  input  logic        [31:0]                  master_volume,
  input  logic signed [31:0]                  num_enabled,
  output logic signed [WIDTH+FIXED_POINT-1:0] out
);

  // Sample width, and the sum width that can hold N full-scale voices.
  localparam int SW    = WIDTH + FIXED_POINT;
  localparam int SUMW  = SW + $clog2(N_WAVEGENS);
  // Voice count index: must represent 1..N_WAVEGENS.
  localparam int NBITS = $clog2(N_WAVEGENS + 1);
  // Reciprocals are Q0.24; 2^24 itself (n = 1) needs 25 bits.
  localparam int RECIP_FRAC = 24;
  localparam int RW   = RECIP_FRAC + 1;
  // Product of sum and zero-extended reciprocal.
  localparam int P1W  = SUMW + RW + 1;
  // The ceil'd reciprocal can push |norm| one LSB past |sum|/n; one spare bit.
  localparam int NRMW = SUMW + 1;
  // Product of norm and zero-extended 32-bit volume.
  localparam int P2W  = NRMW + 33;

  // ---------------------------------------------------------------------------
  // Reciprocal table: ceil(2^24 / n) for n = 1..N_WAVEGENS. Each entry is a
  // constant expression, so only the selection mux remains in hardware.
  // ---------------------------------------------------------------------------
  logic [RW-1:0] recip_tbl [1:N_WAVEGENS];

  for (genvar g = 1; g <= N_WAVEGENS; g++) begin : g_recip
    assign recip_tbl[g] = RW'((64'd16777216 + 64'(g) - 64'd1) / 64'(g));
  end

  // ---------------------------------------------------------------------------
  // Stage 1: sum and voice-count clamp
  // ---------------------------------------------------------------------------
  logic signed [SUMW-1:0]  sum_d, sum_q;
  logic        [NBITS-1:0] n_d,   n_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_WAVEGENS; i++) begin
      sum_d = sum_d + SUMW'(waves[i]);
    end
  end

  // num_enabled <= 0 behaves as a single voice so the table index is never 0.
  always_comb begin
    if (num_enabled <= 32'sd1) begin
      n_d = NBITS'(1);
    end else if (num_enabled >= $signed(32'(N_WAVEGENS))) begin
      n_d = NBITS'(N_WAVEGENS);
    end else begin
      n_d = NBITS'(num_enabled);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum_q <= '0;
      n_q   <= NBITS'(1);
    end else begin
      sum_q <= sum_d;
      n_q   <= n_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: normalise by the voice count, capture volume
  // ---------------------------------------------------------------------------
  logic        [RW-1:0]   recip_sel;
  logic signed [P1W-1:0]  prod1;
  logic signed [NRMW-1:0] norm_d, norm_q;
  logic        [31:0]     vol_d,  vol_q;

  always_comb begin
    recip_sel = recip_tbl[n_q];
    prod1     = P1W'(sum_q) * P1W'($signed({1'b0, recip_sel}));
    // Arithmetic shift floors toward minus infinity for negative sums.
    norm_d    = NRMW'(prod1 >>> RECIP_FRAC);
    vol_d     = master_volume;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      norm_q <= '0;
      vol_q  <= '0;
    end else begin
      norm_q <= norm_d;
      vol_q  <= vol_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: apply volume and saturate
  // ---------------------------------------------------------------------------
  logic signed [P2W-1:0] prod2;
  logic signed [P2W-1:0] scaled;
  logic                  fits;
  logic signed [SW-1:0]  out_d, out_q;

  always_comb begin
    // Volume is unsigned: zero-extend before the signed multiply.
    prod2  = P2W'(norm_q) * P2W'($signed({1'b0, vol_q}));
    scaled = prod2 >>> FIXED_POINT;
    // The value fits in SW bits when every bit above the SW-bit sign bit
    // repeats that sign bit.
    fits   = (scaled[P2W-1:SW-1] == {(P2W-SW+1){scaled[SW-1]}});
    if (fits) begin
      out_d = scaled[SW-1:0];
    end else if (scaled[P2W-1]) begin
      out_d = {1'b1, {(SW-1){1'b0}}};
    end else begin
      out_d = {1'b0, {(SW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_mixer.sv
// -----------------------------------------------------------------------------
// tb_mixer
//   Directed bench for mixer with WIDTH=24, FIXED_POINT=8, N_WAVEGENS=8.
//   The driver applies one vector per clock and pushes the expected output
//   window (lo..hi, exact vectors use lo == hi) into a queue. A tb-side
//   three-stage issue pipeline marks the cycles where an issued vector reaches
//   out; the monitor pops and compares on those cycles.
// -----------------------------------------------------------------------------
module tb_mixer;

  localparam int WIDTH = 24;
  localparam int FP    = 8;
  localparam int NV    = 8;
  localparam int SW    = WIDTH + FP;

  localparam logic signed [SW-1:0] S    = 32'sd256000;      // 1000 << 8
  localparam logic signed [SW-1:0] MAXP = 32'sh7FFF_FFFF;
  localparam logic signed [SW-1:0] MINN = 32'sh8000_0000;
  localparam logic [31:0]          ONE  = 32'd256;          // 1.0 volume

  typedef logic signed [SW-1:0] wv_t [NV];

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                 clk  = 1'b0;
  logic                 rstn = 1'b0;
  logic signed [SW-1:0] waves [NV];
  logic        [31:0]   master_volume;
  logic signed [31:0]   num_enabled;
  logic signed [SW-1:0] out;

  always #5 clk = ~clk;

  mixer #(
    .WIDTH       (WIDTH),
    .FIXED_POINT (FP),
    .N_WAVEGENS  (NV)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .waves         (waves),
    .master_volume (master_volume),
    .num_enabled   (num_enabled),
    .out           (out)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int                   n_vec  = 0;
  int                   n_miss = 0;
  logic signed [SW-1:0] exp_lo_q [$];
  logic signed [SW-1:0] exp_hi_q [$];
  string                name_q   [$];

  logic        issued   = 1'b0;
  logic [2:0]  pipe     = 3'b000;
  logic [31:0] vol_pend = 32'd256;

  // Tracks when an issued vector reaches out (three capture edges).
  always @(posedge clk or negedge rstn) begin
    if (!rstn) pipe <= 3'b000;
    else       pipe <= {pipe[1:0], issued};
  end

  task automatic check(input string nm, input logic signed [SW-1:0] act,
                       input logic signed [SW-1:0] lo, input logic signed [SW-1:0] hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_miss++;
      $display("FAIL %s: out=%0d expected %0d..%0d (t=%0t)", nm, act, lo, hi, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] mon_lo, mon_hi;
  string                mon_nm;

  always @(negedge clk) begin
    if (rstn && pipe[2]) begin
      if (exp_lo_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_output: out=%0d with no expected entry", out);
      end else begin
        mon_lo = exp_lo_q.pop_front();
        mon_hi = exp_hi_q.pop_front();
        mon_nm = name_q.pop_front();
        check(mon_nm, out, mon_lo, mon_hi);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Volume for a vector is driven one cycle after its waves, matching the
  // point where the design samples it.
  task automatic drive(input string nm, input wv_t w, input logic signed [31:0] n,
                       input logic [31:0] vol, input logic signed [SW-1:0] lo,
                       input logic signed [SW-1:0] hi);
    @(negedge clk);
    waves         = w;
    num_enabled   = n;
    master_volume = vol_pend;
    vol_pend      = vol;
    issued        = 1'b1;
    exp_lo_q.push_back(lo);
    exp_hi_q.push_back(hi);
    name_q.push_back(nm);
  endtask

  task automatic idle();
    @(negedge clk);
    waves         = '{default: '0};
    num_enabled   = 32'sd1;
    master_volume = vol_pend;
    issued        = 1'b0;
  endtask

  // Keeps the current waves on the inputs without issuing a new vector.
  task automatic hold();
    @(negedge clk);
    master_volume = vol_pend;
    issued        = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int  ph   [6];
  int  step [6];
  wv_t sw;

  initial begin
    waves         = '{default: S};
    num_enabled   = 32'sd3;
    master_volume = ONE;

    // Reset held with nonzero inputs: out must stay 0.
    repeat (3) @(posedge clk);
    #1 check("rst_hold_a", out, 0, 0);
    @(negedge clk);
    check("rst_hold_b", out, 0, 0);
    rstn = 1'b1;

    // Directed vectors, issued back to back.
    drive("post_rst",   '{S, S, S, 0, 0, 0, 0, 0}, 3, ONE, S - 1, S + 1);
    drive("half_vol",   '{S, S, S, 0, 0, 0, 0, 0}, 3, 32'd128, 32'sd127999, 32'sd128001);
    drive("zero_vol",   '{S, S, S, 0, 0, 0, 0, 0}, 3, 32'd0, 0, 0);
    drive("n0_as_1",    '{-S, 0, 0, 0, 0, 0, 0, 0}, 0, ONE, -S, -S);
    drive("n99_clamp",  '{-S, 0, 0, 0, 0, 0, 0, 0}, 99, ONE, -32'sd32000, -32'sd32000);
    drive("nneg_as_1",  '{-S, 0, 0, 0, 0, 0, 0, 0}, -5, ONE, -S, -S);
    drive("frac_pos",   '{1000, 0, 0, 0, 0, 0, 0, 0}, 3, ONE, 333, 333);
    drive("frac_neg",   '{-1000, 0, 0, 0, 0, 0, 0, 0}, 3, 32'd768, -32'sd1002, -32'sd1002);
    drive("mix_pm",     '{S, -128000, 0, 0, 0, 0, 0, 0}, 2, ONE, 64000, 64000);
    drive("n7",         '{700, 700, 700, 700, 700, 700, 700, 0}, 7, ONE, 700, 700);
    drive("n8_vol2",    '{default: 800}, 8, 32'd512, 1600, 1600);
    drive("all_zero",   '{default: 0}, 2, 32'd1024, 0, 0);
    drive("max_unity",  '{MAXP, 0, 0, 0, 0, 0, 0, 0}, 1, ONE, MAXP, MAXP);
    drive("sat_pos_257",'{MAXP, 0, 0, 0, 0, 0, 0, 0}, 1, 32'd257, MAXP, MAXP);
    drive("sat_pos",    '{default: MAXP}, 1, 32'd1024, MAXP, MAXP);
    drive("sat_neg",    '{default: MINN}, 1, 32'd1024, MINN, MINN);
    drive("min_unity",  '{MINN, 0, 0, 0, 0, 0, 0, 0}, 1, ONE, MINN, MINN);
    repeat (4) idle();

    // Asynchronous reset while out holds a saturated value.
    drive("pre_rst_a",  '{default: MAXP}, 1, 32'd1024, MAXP, MAXP);
    drive("pre_rst_b",  '{default: MAXP}, 1, 32'd1024, MAXP, MAXP);
    repeat (4) hold();
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 check("async_rst", out, 0, 0);
    @(negedge clk);
    check("async_rst_hold", out, 0, 0);
    waves = '{default: '0};
    rstn  = 1'b1;
    repeat (3) idle();

    // Sawtooth voices 0-2, then hand-off to retriggered voices 3-5.
    step = '{11000, 8241, 6930, 11000, 8241, 6930};
    ph   = '{-256000, -100000, 50000, 0, 0, 0};
    for (int c = 0; c < 300; c++) begin
      sw = '{default: '0};
      for (int v = 0; v < 3; v++) begin
        int k;
        k = (c < 150) ? v : v + 3;
        sw[k] = ph[k];
        ph[k] = ph[k] + step[k];
        if (ph[k] > 256000) ph[k] = ph[k] - 512000;
      end
      drive((c < 150) ? "saw_low" : "saw_handoff", sw, 3, ONE, -S - 1, S + 1);
    end
    repeat (5) idle();

    n_vec++;
    if (exp_lo_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_lo_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

endmodule
